// File: rtl/uart_rx_if.sv
// UART receiver bus: serial line plus per-frame configuration in, received
// word and status strobes out. The bench drives the master side.
interface uart_rx_if #(
  parameter int data_width = 8
);
  logic                  rx_in;
  logic [5:0]            prescale;
  logic                  par_en;
  logic                  par_typ;
  logic [data_width-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output rx_in, prescale, par_en, par_typ,
    input  p_data, data_valid, par_err, stp_err
  );

  modport slave (
    input  rx_in, prescale, par_en, par_typ,
    output p_data, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver (start, data_width data bits LSB first,
// optional parity, one stop bit). The cycle in which IDLE first sees rx_in
// low counts as edge 0 of the start bit, so a frame of N bits ends (strobes
// and p_data update visible) exactly N*P cycles after that cycle.
// Optional build macro RX_MAJORITY_SAMPLE_EN: decide each bit by a 2-of-3
// vote over edges P/2-1, P/2, P/2+1 instead of a single sample at P/2.
module uart_rx #(
  parameter int data_width = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int BCW = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(data_width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nx;
  logic [5:0]            edge_cnt, edge_nx;
  logic [BCW-1:0]        bit_cnt, bit_nx;
  logic [data_width-1:0] shreg, shreg_nx;
  logic [data_width-1:0] p_data_q, p_data_nx;
  logic                  par_fail, par_fail_nx;
  logic                  stp_fail, stp_fail_nx;
  logic [5:0]            pre_q, pre_nx;
  logic                  pen_q, pen_nx;
  logic                  ptyp_q, ptyp_nx;
  logic                  dv_q, dv_nx;
  logic                  pe_q, pe_nx;
  logic                  se_q, se_nx;
  logic [5:0]            half;
  logic                  bit_end;
  logic                  decide;
  logic                  bit_val;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic exp_parity(input logic [data_width-1:0] d, input logic odd);
    return odd ? ~(^d) : (^d);
  endfunction

  assign half    = pre_q >> 1;
  assign bit_end = (edge_cnt == pre_q - 6'd1);

`ifdef RX_MAJORITY_SAMPLE_EN
  logic [1:0] smp_q, smp_nx;
  assign decide  = (edge_cnt == half + 6'd1);
  assign bit_val = maj3(smp_q[1], smp_q[0], bus.rx_in);
`else
  assign decide  = (edge_cnt == half);
  assign bit_val = bus.rx_in;
`endif

  // Next-state, counter, shift register and strobe logic
  always_comb begin
    state_nx    = state;
    edge_nx     = edge_cnt;
    bit_nx      = bit_cnt;
    shreg_nx    = shreg;
    par_fail_nx = par_fail;
    stp_fail_nx = stp_fail;
    pre_nx      = pre_q;
    pen_nx      = pen_q;
    ptyp_nx     = ptyp_q;
    p_data_nx   = p_data_q;
    dv_nx       = 1'b0;
    pe_nx       = 1'b0;
    se_nx       = 1'b0;
`ifdef RX_MAJORITY_SAMPLE_EN
    smp_nx = smp_q;
    if (edge_cnt == half - 6'd1) smp_nx[1] = bus.rx_in;
    if (edge_cnt == half)        smp_nx[0] = bus.rx_in;
`endif
    if (state != IDLE) edge_nx = bit_end ? 6'd0 : edge_cnt + 6'd1;

    case (state)
      IDLE: begin
        edge_nx = 6'd0;
        bit_nx  = '0;
        if (!bus.rx_in) begin
          // This cycle is edge 0 of the start bit; config is frozen here.
          state_nx    = START;
          edge_nx     = 6'd1;
          shreg_nx    = '0;
          par_fail_nx = 1'b0;
          stp_fail_nx = 1'b0;
          pre_nx      = bus.prescale;
          pen_nx      = bus.par_en;
          ptyp_nx     = bus.par_typ;
        end
      end
      START: begin
        if (decide && bit_val) begin
          state_nx = IDLE;
          edge_nx  = 6'd0;
        end else if (bit_end) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        if (decide) begin
          shreg_nx                 = shreg >> 1;
          shreg_nx[data_width-1]   = bit_val;
        end
        if (bit_end) begin
          if (bit_cnt == LAST_BIT) begin
            bit_nx   = '0;
            state_nx = pen_q ? PARITY : STOP;
          end else begin
            bit_nx = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (decide && (bit_val != exp_parity(shreg, ptyp_q))) par_fail_nx = 1'b1;
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        if (decide && !bit_val) stp_fail_nx = 1'b1;
        if (bit_end) begin
          state_nx  = IDLE;
          p_data_nx = shreg;
          dv_nx     = !par_fail && !stp_fail;
          pe_nx     = par_fail;
          se_nx     = stp_fail;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      p_data_q <= '0;
      par_fail <= 1'b0;
      stp_fail <= 1'b0;
      pre_q    <= '0;
      pen_q    <= 1'b0;
      ptyp_q   <= 1'b0;
      dv_q     <= 1'b0;
      pe_q     <= 1'b0;
      se_q     <= 1'b0;
`ifdef RX_MAJORITY_SAMPLE_EN
      smp_q    <= '0;
`endif
    end else begin
      state    <= state_nx;
      edge_cnt <= edge_nx;
      bit_cnt  <= bit_nx;
      shreg    <= shreg_nx;
      p_data_q <= p_data_nx;
      par_fail <= par_fail_nx;
      stp_fail <= stp_fail_nx;
      pre_q    <= pre_nx;
      pen_q    <= pen_nx;
      ptyp_q   <= ptyp_nx;
      dv_q     <= dv_nx;
      pe_q     <= pe_nx;
      se_q     <= se_nx;
`ifdef RX_MAJORITY_SAMPLE_EN
      smp_q    <= smp_nx;
`endif
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = dv_q;
  assign bus.par_err    = pe_q;
  assign bus.stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives whole frames on the serial line, predicts each
// frame's end cycle and outcome from the frame contents, and compares the
// DUT outputs against that prediction every cycle, plus literal checkpoints.
module tb_uart_rx;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   ntests = 0;
  int   nfail  = 0;
  bit   chk_en = 1'b0;

  uart_rx_if #(.data_width(DW)) bus();
  uart_rx #(.data_width(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [DW-1:0] d;
    logic        dv;
    logic        pe;
    logic        se;
  } exp_t;

  exp_t          ev_q[$];
  exp_t          lit_q[$];
  logic [DW-1:0] exp_pdata = '0;

  task automatic chk(input string name, input exp_t e);
    ntests++;
    if (bus.p_data !== e.d || bus.data_valid !== e.dv ||
        bus.par_err !== e.pe || bus.stp_err !== e.se) begin
      nfail++;
      $display("FAIL %s cyc=%0d got p_data=%h dv=%b pe=%b se=%b want p_data=%h dv=%b pe=%b se=%b",
               name, cyc, bus.p_data, bus.data_valid, bus.par_err, bus.stp_err,
               e.d, e.dv, e.pe, e.se);
    end
  endtask

  task automatic lit(input int c, input logic [DW-1:0] d, input logic dv,
                     input logic pe, input logic se);
    exp_t e;
    e.cyc = c; e.d = d; e.dv = dv; e.pe = pe; e.se = se;
    lit_q.push_back(e);
  endtask

  // Per-cycle comparison against the frame model and the literal checkpoints
  always @(negedge clk) begin
    exp_t m;
    if (chk_en) begin
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        ntests++; nfail++;
        $display("FAIL model_event_missed cyc=%0d want_cyc=%0d", cyc, ev_q[0].cyc);
        void'(ev_q.pop_front());
      end
      m.cyc = cyc; m.d = exp_pdata; m.dv = 1'b0; m.pe = 1'b0; m.se = 1'b0;
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        m = ev_q.pop_front();
        exp_pdata = m.d;
      end
      chk("model", m);
      while (lit_q.size() > 0 && lit_q[0].cyc < cyc) begin
        ntests++; nfail++;
        $display("FAIL literal_missed cyc=%0d want_cyc=%0d", cyc, lit_q[0].cyc);
        void'(lit_q.pop_front());
      end
      if (lit_q.size() > 0 && lit_q[0].cyc == cyc) chk("literal", lit_q.pop_front());
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.rx_in = 1'b1;
    end
  endtask

  task automatic do_reset();
    exp_t z;
    rst = 1'b0;
    bus.rx_in = 1'b1;
    ev_q.delete();
    lit_q.delete();
    exp_pdata = '0;
    #1;
    z.cyc = cyc; z.d = '0; z.dv = 1'b0; z.pe = 1'b0; z.se = 1'b0;
    chk("reset_immediate", z);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Drives one frame; s returns the cycle index of the start bit's first cycle.
  task automatic send_frame(input logic [DW-1:0] d, input int p, input bit pen,
                            input bit ptyp, input bit pbit, input bit sbit,
                            input int abort_at, input bit scramble, input bit glitch,
                            output int s);
    bit   bits[0:DW+2];
    int   n;
    exp_t e;
    logic ep;
    n = DW + 2 + int'(pen);
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1+i] = d[i];
    if (pen) bits[DW+1] = pbit;
    bits[n-1] = sbit;
    s = 0;
    for (int c = 0; c < n * p; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        s = cyc;
        bus.prescale = 6'(p);
        bus.par_en   = pen;
        bus.par_typ  = ptyp;
        if (abort_at < 0) begin
          ep   = ptyp ? ~(^d) : (^d);
          e.cyc = s + n * p;
          e.d  = d;
          e.pe = pen && (pbit != ep);
          e.se = !sbit;
          e.dv = !e.pe && !e.se;
          ev_q.push_back(e);
        end
      end
      if (c == abort_at) begin
        do_reset();
        return;
      end
      if (scramble && c == 3 * p) begin
        bus.prescale = 6'd8;
        bus.par_typ  = ~ptyp;
        bus.par_en   = ~pen;
      end
      bus.rx_in = bits[c / p];
      if (glitch && (c / p) >= 1 && (c / p) <= DW && (c % p) == p / 2)
        bus.rx_in = ~bus.rx_in;
    end
  endtask

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog cyc=%0d limit=40000", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int   s;
    int   s2;
    exp_t z;
    rst          = 1'b1;
    bus.rx_in    = 1'b1;
    bus.prescale = 6'd8;
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;
    #2 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    z.cyc = cyc; z.d = '0; z.dv = 1'b0; z.pe = 1'b0; z.se = 1'b0;
    chk("reset_state", z);
    idle(5);

    // Good frame, even parity, P=8
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0, s);
    lit(s + 88, 8'hA5, 1'b1, 1'b0, 1'b0);
    idle(10);

    // Bad odd parity, P=16, config inputs disturbed mid-frame
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b1, 1'b0, s);
    lit(s + 176, 8'h3C, 1'b0, 1'b1, 1'b0);
    idle(10);

    // Back-to-back, no parity, P=32
    send_frame(8'h00, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0, s);
    lit(s + 320, 8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0, s2);
    lit(s + 640, 8'hFF, 1'b1, 1'b0, 1'b0);
    idle(10);

    // False start: 4-cycle low glitch at P=16, then a clean frame
    @(posedge clk); #1;
    bus.prescale = 6'd16;
    bus.par_en   = 1'b0;
    bus.rx_in    = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    idle(30);
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0, s);
    lit(s + 160, 8'h55, 1'b1, 1'b0, 1'b0);
    idle(10);

    // Stop error, then reset in the middle of the following frame
    send_frame(8'h81, 8, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, s);
    lit(s + 88, 8'h81, 1'b0, 1'b0, 1'b1);
    send_frame(8'h33, 8, 1'b1, 1'b0, 1'b0, 1'b1, 40, 1'b0, 1'b0, s2);
    idle(5);

    // First frame after reset, odd parity good
    send_frame(8'h5A, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b0, s);
    lit(s + 176, 8'h5A, 1'b1, 1'b0, 1'b0);
    idle(10);

    // Line held low: two all-zero frames, each with a low stop bit
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, s);
    lit(s + 80, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, s2);
    lit(s + 160, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(10);

`ifdef RX_MAJORITY_SAMPLE_EN
    // Centre-sample glitch in every data bit is outvoted
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1, s);
    lit(s + 88, 8'hA5, 1'b1, 1'b0, 1'b0);
    idle(10);
`endif

    idle(5);
    @(negedge clk);
    ntests++;
    if (ev_q.size() != 0 || lit_q.size() != 0) begin
      nfail++;
      $display("FAIL pending_expectations got model=%0d literal=%0d want 0 0",
               ev_q.size(), lit_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter data_width, default 8, SHALL set the number of data bits per frame and the width of p_data.
REQ-002 clk  input  1  single clock for all state.
REQ-003 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 rx_in  input  1  serial line, idle high, already synchronised to clk.
REQ-005 prescale  input  6  oversampling ratio P; only 8, 16 and 32 are legal.
REQ-006 par_en  input  1  SHALL indicate that a parity bit is present when high.
REQ-007 par_typ  input  1  parity type: 0 = even, 1 = odd.
REQ-008 p_data  output  data_width  received data word.
REQ-009 data_valid  output  1  one-cycle strobe marking a good frame.
REQ-010 par_err  output  1  one-cycle strobe marking a parity mismatch.
REQ-011 stp_err  output  1  one-cycle strobe marking a low stop bit.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP. An edge counter SHALL run 0..P-1 per bit period, and a bit counter SHALL run 0..data_width-1.
REQ-013 In IDLE, when rx_in is low, the FSM SHALL enter START with the edge counter at 0. This is cycle 0 of the frame.
REQ-014 prescale, par_en and par_typ SHALL be captured at cycle 0 and held for the whole frame. Input changes mid-frame SHALL be ignored.
REQ-015 Each bit value SHALL be decided when edge_cnt == P/2.
REQ-016 In START, a decided value of 1 is a false start: the FSM SHALL return to IDLE with no strobes. A decided value of 0 SHALL move the FSM to DATA when edge_cnt == P-1.
REQ-017 In DATA, bits SHALL be shifted in LSB first. After bit data_width-1 completes, the FSM SHALL go to PARITY if par_en=1, otherwise to STOP.
REQ-018 The expected parity SHALL be computed over the received data: ^data when par_typ=0, and ~(^data) when par_typ=1. A received parity bit that differs SHALL set an internal parity-fail flag.
REQ-019 In STOP, a decided value of 0 SHALL set an internal stop-fail flag.
REQ-020 Frame end SHALL be the cycle after STOP reaches edge_cnt == P-1, which is cycle (data_width+2+par_en)*P.
REQ-021 At frame end:
- p_data SHALL update.
- data_valid SHALL pulse only if both fail flags are clear.
- par_err and stp_err SHALL pulse according to their flags.
- The FSM SHALL return to IDLE.
REQ-022 p_data SHALL hold its value until the next frame end. Strobes SHALL never exceed one cycle.
REQ-023 Back-to-back frames SHALL be accepted: a low rx_in on the first IDLE cycle after frame end starts the next frame.
REQ-024 A line held low SHALL produce stp_err and no data_valid, then start a new frame on the next IDLE cycle.

Reset
REQ-025 Asserting rst SHALL immediately force:
- FSM to IDLE;
- all counters, shift register and fail flags to 0;
- p_data, data_valid, par_err and stp_err to 0.
REQ-026 A reset asserted mid-frame SHALL discard the partial frame with no strobes.
REQ-027 After reset is released, the first cycle with rx_in low SHALL be treated as a start edge.

Configuration
REQ-028 With RX_MAJORITY_SAMPLE_EN defined, each bit value SHALL be the 2-of-3 majority of rx_in sampled at edge_cnt P/2-1, P/2 and P/2+1. The decision SHALL take effect at P/2+1, and the false-start check SHALL use the majority.
REQ-029 Without RX_MAJORITY_SAMPLE_EN, each bit value SHALL be the single rx_in sample at edge_cnt == P/2.

Verification
REQ-030 Good frame, even parity: P=8, par_en=1, par_typ=0, frame 0xA5 (parity 0, stop 1) -> data_valid at cycle 88, p_data=0xA5, no errors.
REQ-031 Bad parity: P=16, par_typ=1, frame 0x3C with parity bit 0 -> par_err pulse at cycle 176, no data_valid, p_data=0x3C.
REQ-032 No parity, back-to-back: P=32, par_en=0, frames 0x00 then 0xFF -> data_valid at cycles 320 and 640 with p_data 0x00 then 0xFF.
REQ-033 False start: P=16, a 4-cycle low glitch in IDLE -> FSM back in IDLE, no strobes; a subsequent 0x55 frame is received correctly.
REQ-034 Error and reset: P=8, frame 0x81 with stop bit 0 -> stp_err at cycle 88. Reset asserted at cycle 40 of the next frame -> all outputs 0 and no strobes.
REQ-035 Majority vote: with RX_MAJORITY_SAMPLE_EN defined, a one-cycle inverted glitch at edge_cnt P/2 in every data bit -> 0xA5 still received.
